// File: rtl/out_port_pkg.sv
// Shared types and constants for the out-port UART transmitter.
// Byte selection helper keeps the MSB-first ordering in one place.
package out_port_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

  localparam int BYTES_PER_WORD       = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Byte 0 is the most significant byte of the word.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    word_byte = w[31:24];
      2'd1:    word_byte = w[23:16];
      2'd2:    word_byte = w[15:8];
      default: word_byte = w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with wrap-bit pointers; write visible to the reader one edge later.
// No backpressure: a push while full is discarded and reported on drop.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign drop     = push & full;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/out_port_uart_tx.sv
// Queues out-port words and sends each as four 8N1 bytes, MSB byte first; tx falls one edge after the write.
// Never stalls the writer: words arriving while full are dropped and flagged on sticky overflow.
module out_port_uart_tx
  import out_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [31:0]                 wr_data,
  output logic                        tx,
  output logic                        busy,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  tx_state_t   state;
  tx_state_t   state_d;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  shift_d;
  logic        tx_d;
  logic        pop;
  logic        empty;
  logic        drop;
  logic        baud_done;
  logic [31:0] head;

  word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .clear     (clear),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .drop      (drop)
  );

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE) | ~empty;

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (!empty) state_d = START;
      START:   if (baud_done) state_d = DATA;
      DATA:    if (baud_done && bit_idx == 3'd7) state_d = STOP;
      STOP:    if (baud_done) state_d = (byte_idx != LAST_BYTE) ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx is registered, so it is computed from the state and shift value being entered.
  always_comb begin
    pop     = 1'b0;
    shift_d = shift_reg;
    tx_d    = 1'b1;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_d = word_byte(head, 2'd0);
      end
      DATA: if (baud_done) shift_d = shift_reg >> 1;
      STOP: if (baud_done && byte_idx != LAST_BYTE) shift_d = word_byte(word_reg, byte_idx + 2'd1);
      default: ;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      tx        <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      word_reg  <= '0;
      shift_reg <= '0;
      overflow  <= 1'b0;
    end else begin
      tx        <= tx_d;
      shift_reg <= shift_d;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        word_reg <= head;
        byte_idx <= 2'd0;
      end
      if (state == IDLE || baud_done) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;
      if (state == START && baud_done) bit_idx <= 3'd0;
      if (state == DATA && baud_done)  bit_idx <= bit_idx + 1'b1;
      if (state == STOP && baud_done && byte_idx != LAST_BYTE) byte_idx <= byte_idx + 1'b1;
    end
  end

endmodule

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
- Downstream consumer of the CPU datapath's output port.
- Each word the CPU writes to the out port (enableOutPort strobe plus out_port_data_out) is queued in a small word FIFO.
- Each queued word is serialized as four UART 8N1 bytes on a single tx pin for host/terminal observation of program output.
- Lets test programs stream results off-board without stalling the CPU; overflow is flagged, not back-pressured.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, word entries in the queue; power of two, at least 2.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  synchronous active-high reset.
- wr_en  in  1  write strobe, tied to the datapath's out-port enable; one word per high cycle.
- wr_data  in  32  word to transmit (BusMuxOut value at the out-port load).
- tx  out  1  UART serial line, idle high.
- busy  out  1  high while a frame is in progress or the FIFO is non-empty.
- full  out  1  FIFO holds FIFO_DEPTH words.
- count  out  $clog2(FIFO_DEPTH)+1  number of words queued (excludes the word being shifted).
- overflow  out  1  sticky; set when a write is dropped.

Behaviour:
- Reset: one clock with clear high sets tx=1, busy=0, full=0, count=0, overflow=0.
- Reset also flushes the FIFO and forces the FSM to IDLE.
- clear wins over every other event. Reset mid-frame aborts the frame; tx is 1 after that edge.
- FIFO: registered read/write pointers with one extra wrap bit. full = (ptr MSBs differ and low bits equal). count = wr_ptr - rd_ptr.
- Write: wr_en & ~full stores wr_data at the edge.
- Write while full: wr_en & full drops the word, leaves the FIFO unchanged, and sets overflow. This holds even if a pop occurs on the same edge, because full is sampled pre-edge.
- Overflow clears only on clear.
- Simultaneous push and pop when not full: both happen; count is unchanged.
- FSM states: IDLE, START, DATA, STOP. It uses:
  - baud counter, 0..CLKS_PER_BIT-1;
  - bit index, 0..7;
  - byte index, 0..3;
  - 32-bit word register;
  - 8-bit shift register.
- IDLE: tx=1. If count>0, pop the head into the word register, load the shift register with word[31:24], set byte index=0, and enter START.
- Byte order is most-significant byte first.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, shifting right after each bit. After bit 7 go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - if byte index<3, increment it, load the next byte (word[23:16], [15:8], [7:0]) and go to START with no idle gap;
  - otherwise go to IDLE.
- tx is a registered output.
- Latency: wr_en sampled at edge E0 into an empty FIFO with the FSM in IDLE. At E1 the FSM pops and enters START; tx=0 is visible after E1.
- Per-word frame length: exactly 40*CLKS_PER_BIT cycles from tx falling to the end of the final stop bit.
- Back-to-back words: after the last stop bit, IDLE lasts exactly one cycle before the next pop, so there are CLKS_PER_BIT+1 high cycles between frames.
- busy = (state != IDLE) | (count != 0).
- Arithmetic: the baud counter compares against CLKS_PER_BIT-1 with no off-by-one. Pointers wrap modulo 2*FIFO_DEPTH.

Decomposition:
- Shared package out_port_pkg holds:
  - state enum {IDLE, START, DATA, STOP} as 2-bit encoding 00/01/10/11;
  - BYTES_PER_WORD=4;
  - default CLKS_PER_BIT=434.
- One sub-module, word_fifo: a parameterised synchronous FIFO with push, pop, full, empty, count and drop-detect output.
- The top level holds the FSM, baud counter, shift logic and overflow flag.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then idle 50 cycles -> tx=1, busy=0, count=0 throughout.
- Single write 0x41424344 -> tx falls one edge after the write edge. The line decodes bytes 0x41,0x42,0x43,0x44 in order, each 8N1 at 4 cycles/bit. busy drops exactly 160 cycles after tx first falls.
- Five writes on consecutive cycles (0x00000001..0x00000005) -> the first is popped at the second edge. count peaks at 4 and full rises; all five words are transmitted and overflow stays 0.
- Six writes on consecutive cycles -> the sixth word is dropped, overflow=1 and sticky. Exactly five words appear on tx.
- Write 0xFFFFFFFF, then 0x00000000 immediately after the first frame's last stop bit -> exactly 5 high cycles of tx between frames; the second frame is all-zero data bits.
- Assert clear during DATA of byte 2 with 2 words queued -> tx=1 and count=0 after that edge, overflow=0. No further frames are sent.
